// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter.
// Bus widths, FSM state encoding and one-hot decode.
package bus_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection for the memory bus arbiter.
// Round-robin when BUS_ARB_ROUND_ROBIN_EN is defined, else fixed priority.
module bus_arb_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_req
);

    assign any_req = |req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Walk downward so the smallest offset past rr_ptr is written last.
    always_comb begin
        int                   idx;
        logic [NUM_MASTERS-1:0] sh;
        winner = '0;
        idx    = 0;
        sh     = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            sh  = req >> idx;
            if (sh[0]) begin
                winner = IDX_W'(idx);
            end
        end
    end
`else
    logic rr_unused;
    assign rr_unused = ^rr_ptr;

    always_comb begin
        logic [NUM_MASTERS-1:0] sh;
        winner = '0;
        sh     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            sh = req >> k;
            if (sh[0]) begin
                winner = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: request/grant FSM, bus mux and hold-limit recovery.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module mem_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_HOLD    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        mst_req,
    input  logic [ADDR_W*NUM_MASTERS-1:0] mst_adr,
    input  logic [DATA_W*NUM_MASTERS-1:0] mst_wdata,
    input  logic [NUM_MASTERS-1:0]        mst_r,
    input  logic [NUM_MASTERS-1:0]        mst_w,
    output logic [NUM_MASTERS-1:0]        mst_grant,
    output logic [DATA_W-1:0]             mst_rdata,
    output logic [ADDR_W-1:0]             mem_adr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_r,
    output logic                          mem_w,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          hold_timeout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] mst_grant_q, mst_grant_d;
    logic                   hold_timeout_q, hold_timeout_d;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   others_req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && any_req) begin
            rr_ptr_d = winner;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = IDX_W'(NUM_MASTERS - 1);
`endif

    bus_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req    (mst_req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any_req(any_req)
    );

    assign owner_oh   = NUM_MASTERS'(onehot8(3'(owner_q)));
    assign others_req = |(mst_req & ~owner_oh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            hold_cnt_q     <= '0;
            mst_grant_q    <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            hold_cnt_q     <= hold_cnt_d;
            mst_grant_q    <= mst_grant_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        hold_cnt_d     = hold_cnt_q;
        mst_grant_d    = mst_grant_q;
        hold_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = GRANT;
                    owner_d     = winner;
                    hold_cnt_d  = '0;
                    mst_grant_d = NUM_MASTERS'(onehot8(3'(winner)));
                end
            end
            GRANT: begin
                if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // A voluntary release wins over the hold limit on the same edge.
                if (!mst_req[owner_q]) begin
                    state_d     = TURN;
                    mst_grant_d = '0;
                end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST
                             && others_req) begin
                    state_d        = TURN;
                    mst_grant_d    = '0;
                    hold_timeout_d = 1'b1;
                end
            end
            TURN: begin
                state_d     = IDLE;
                hold_cnt_d  = '0;
                mst_grant_d = '0;
            end
            default: begin
                state_d     = IDLE;
                mst_grant_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        if (state_q == GRANT) begin
            mem_adr   = mst_adr[int'(owner_q)*ADDR_W +: ADDR_W];
            mem_wdata = mst_wdata[int'(owner_q)*DATA_W +: DATA_W];
            mem_w     = mst_w[owner_q];
            mem_r     = mst_r[owner_q] & ~mst_w[owner_q];
        end
    end

    assign mst_grant    = mst_grant_q;
    assign hold_timeout = hold_timeout_q;
    assign mst_rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (3 masters, hold limit 4).
// Directed scenarios then random traffic against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int MH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      mst_req;
    logic [16*N-1:0]   mst_adr;
    logic [8*N-1:0]    mst_wdata;
    logic [N-1:0]      mst_r;
    logic [N-1:0]      mst_w;
    logic [N-1:0]      mst_grant;
    logic [7:0]        mst_rdata;
    logic [15:0]       mem_adr;
    logic [7:0]        mem_wdata;
    logic              mem_r;
    logic              mem_w;
    logic [7:0]        mem_rdata;
    logic              hold_timeout;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_MASTERS(N),
        .MAX_HOLD   (MH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mst_req     (mst_req),
        .mst_adr     (mst_adr),
        .mst_wdata   (mst_wdata),
        .mst_r       (mst_r),
        .mst_w       (mst_w),
        .mst_grant   (mst_grant),
        .mst_rdata   (mst_rdata),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .mem_rdata   (mem_rdata),
        .hold_timeout(hold_timeout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Model: owner (-1 = nobody), grant cycles used, dead-cycle flag.
    int m_own   = -1;
    int m_held  = 0;
    bit m_dead  = 0;
    bit m_pulse = 0;
    int m_rr    = N - 1;
    int n_to    = 0;

    function automatic int pick(input logic [N-1:0] r, input int rr);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_held = 0; m_dead = 0; m_pulse = 0; m_rr = N - 1;
    endtask

    task automatic model_step();
        int w;
        logic [N-1:0] others;
        m_pulse = 0;
        if (m_dead) begin
            m_dead = 0;
        end else if (m_own < 0) begin
            w = pick(mst_req, m_rr);
            if (w >= 0) begin
                m_own = w; m_held = 1; m_rr = w;
            end
        end else begin
            others = mst_req;
            others[m_own] = 1'b0;
            if (!mst_req[m_own]) begin
                m_own = -1; m_dead = 1;
            end else if (m_held == MH && others != 0) begin
                m_own = -1; m_dead = 1; m_pulse = 1; n_to++;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        logic [15:0]  ea;
        logic [7:0]   ed;
        logic         er, ew;
        eg = '0; ea = '0; ed = '0; er = 0; ew = 0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ea = mst_adr[m_own*16 +: 16];
            ed = mst_wdata[m_own*8 +: 8];
            ew = mst_w[m_own];
            er = mst_r[m_own] && !mst_w[m_own];
        end
        check("grant", 32'(mst_grant), 32'(eg));
        check("timeout", 32'(hold_timeout), 32'(m_pulse));
        check("mem_adr", 32'(mem_adr), 32'(ea));
        check("mem_wdata", 32'(mem_wdata), 32'(ed));
        check("mem_r", 32'(mem_r), 32'(er));
        check("mem_w", 32'(mem_w), 32'(ew));
        check("rdata", 32'(mst_rdata), 32'(mem_rdata));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic randomize_bus();
        mst_adr   = {$urandom, $urandom};
        mst_wdata = $urandom;
        mst_r     = $urandom;
        mst_w     = $urandom;
        mem_rdata = $urandom;
    endtask

    initial begin
        reset = 1'b0; mst_req = '0; mst_adr = '0; mst_wdata = '0;
        mst_r = '0; mst_w = '0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        steps(2);

        mst_adr[15:0] = 16'h2000; mst_r = 3'b001; mem_rdata = 8'hA5;
        mst_req = 3'b001;
        step();
        check("t1_grant", 32'(mst_grant), 32'h1);
        check("t1_adr", 32'(mem_adr), 32'h2000);
        check("t1_rdata", 32'(mst_rdata), 32'hA5);
        mst_req = '0;
        steps(3);

        mst_req = 3'b111;
        steps(12);
        mst_req = '0;
        steps(3);

        mst_req = 3'b010;
        step();
        mst_req = 3'b110;
        steps(8);
        check("timeouts_seen", 32'(n_to > 0), 32'h1);
        mst_req = '0;
        steps(4);

        mst_req = 3'b010;
        step();
        mst_req = 3'b110;
        steps(3);
        mst_req = 3'b100;
        step();
        check("drop_no_pulse", 32'(hold_timeout), 32'h0);
        steps(3);
        mst_req = '0;
        steps(3);

        mst_adr[15:0] = 16'hFF00; mst_wdata[7:0] = 8'h3C;
        mst_r = 3'b001; mst_w = 3'b001; mst_req = 3'b001;
        steps(2);
        check("rw_mem_w", 32'(mem_w), 32'h1);
        check("rw_mem_r", 32'(mem_r), 32'h0);
        check("rw_wdata", 32'(mem_wdata), 32'h3C);

        mst_req = 3'b010;
        steps(4);
        reset = 1'b0;
        #1;
        check("rst_grant", 32'(mst_grant), 32'h0);
        check("rst_adr", 32'(mem_adr), 32'h0);
        check("rst_strobes", 32'({mem_r, mem_w}), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        mst_req = 3'b111;
        step();
        check("rst_rearb", 32'(mst_grant), 32'h1);
        mst_req = '0;
        steps(3);

        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < N; j++)
                if ($urandom_range(5) == 0) mst_req[j] = ~mst_req[j];
            randomize_bus();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
